// File: rtl/seven_seg_scan_decoder_if.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_decoder_if
//
// Groups the scanned-display inputs and the decoded-frame outputs of
// seven_seg_scan_decoder into one bundle.
//
// Handshake semantics: there is no backpressure. The display driver presents
// an_i/seg_i/dp_i every cycle; the decoder qualifies them purely by stability.
// frame_valid_o is a single-cycle strobe and value_o/dp_o/frame_err_o are
// valid in that cycle (value_o/dp_o then hold until the next strobe).
//
//   an_i           4  anode enables, active-low (bit 0 = rightmost digit)
//   seg_i          7  segments {g,f,e,d,c,b,a}, active-low
//   dp_i           1  decimal point, active-low
//   value_o       16  last complete frame, 4 BCD nibbles (nibble k = digit k)
//   dp_o           4  last complete frame decimal points, active-high
//   frame_valid_o  1  one-cycle pulse when value_o/dp_o update
//   frame_err_o    1  frame contained an undecodable digit (with frame_valid_o)
//   multi_an_err_o 1  one-cycle pulse when several anodes are low
//   timeout_o      1  one-cycle pulse when a partial frame is abandoned
//   state_o        2  debug view of the scan FSM (0 idle, 1 settle, 2 hold)
//
// Modports: master = display driver side, slave = decoder side.
// -----------------------------------------------------------------------------
interface seven_seg_scan_decoder_if;
    logic [3:0]  an_i;
    logic [6:0]  seg_i;
    logic        dp_i;
    logic [15:0] value_o;
    logic [3:0]  dp_o;
    logic        frame_valid_o;
    logic        frame_err_o;
    logic        multi_an_err_o;
    logic        timeout_o;
    logic [1:0]  state_o;

    modport master (
        output an_i, seg_i, dp_i,
        input  value_o, dp_o, frame_valid_o, frame_err_o,
               multi_an_err_o, timeout_o, state_o
    );

    modport slave (
        input  an_i, seg_i, dp_i,
        output value_o, dp_o, frame_valid_o, frame_err_o,
               multi_an_err_o, timeout_o, state_o
    );
endinterface

// File: rtl/seven_seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_decoder
//
// Watches a multiplexed 4-digit seven-segment display bus and reconstructs the
// number being shown. A digit is captured once its anode/segment/dp pattern
// has been stable for SETTLE_CYC consecutive cycles; once all four positions
// have been captured the frame is published on value_o/dp_o with a one-cycle
// frame_valid_o strobe.
//
// Ports:
//   clk_i   rising-edge clock; the display bus is already in this domain
//   rst_ni  asynchronous active-low reset
//   bus     seven_seg_scan_decoder_if.slave (see interface for signal list)
//
// Parameters:
//   SETTLE_CYC   stable cycles needed per capture (2..255)
//   TIMEOUT_CYC  idle cycles before a partial frame is abandoned
//
// Optional feature: define SCAN_TIMEOUT_EN to build the idle counter that
// abandons a partial frame after TIMEOUT_CYC cycles without a capture.
// Without it timeout_o is tied low and a frame may take arbitrarily long.
// -----------------------------------------------------------------------------
module seven_seg_scan_decoder #(
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    seven_seg_scan_decoder_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // The counter is reloaded to 0 on the first cycle of a new pattern, so the
    // capture edge is the one where it would step from SETTLE_CYC-2 to
    // SETTLE_CYC-1: that edge is the SETTLE_CYC-th stable sample.
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 2);

    state_t      state_q, state_d;
    logic [3:0]  an_q;
    logic [6:0]  seg_q;
    logic        dp_q;
    logic [7:0]  settle_cnt_q;
    logic [3:0]  seen_q;
    logic        flag_q;
    logic [15:0] shadow_q;
    logic [3:0]  shadow_dp_q;
    logic [15:0] value_q;
    logic [3:0]  dp_out_q;
    logic        frame_valid_q;
    logic        frame_err_q;
    logic        multi_q;
    logic        timeout_q;

    logic        changed;
    logic [3:0]  an_act;
    logic [3:0]  an_act_prev;
    logic        single_sel;
    logic        multi_sel;
    logic        multi_prev;
    logic [1:0]  sel_idx;
    logic        capture;
    logic        multi_first;
    logic        complete;
    logic        timeout_hit;
    logic [4:0]  dec;

    // Maps an active-low segment pattern to {valid, digit}; unknown -> {0, F}.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h40:   r = 5'h10;
            7'h79:   r = 5'h11;
            7'h24:   r = 5'h12;
            7'h30:   r = 5'h13;
            7'h19:   r = 5'h14;
            7'h12:   r = 5'h15;
            7'h02:   r = 5'h16;
            7'h78:   r = 5'h17;
            7'h00:   r = 5'h18;
            7'h10:   r = 5'h19;
            default: r = 5'h0F;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Input classification
    // ------------------------------------------------------------------
    assign changed     = {bus.an_i, bus.seg_i, bus.dp_i} != {an_q, seg_q, dp_q};
    assign an_act      = ~bus.an_i;
    assign an_act_prev = ~an_q;
    // x & (x-1) drops the lowest set bit: non-zero means two or more selected.
    assign multi_sel   = (an_act & (an_act - 4'd1)) != 4'd0;
    assign multi_prev  = (an_act_prev & (an_act_prev - 4'd1)) != 4'd0;
    assign single_sel  = (an_act != 4'd0) && !multi_sel;
    assign complete    = (seen_q == 4'hF);
    assign dec         = decode(bus.seg_i);

    always_comb begin
        sel_idx = 2'd0;
        case (an_act)
            4'b0001: sel_idx = 2'd0;
            4'b0010: sel_idx = 2'd1;
            4'b0100: sel_idx = 2'd2;
            4'b1000: sel_idx = 2'd3;
            default: sel_idx = 2'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (changed) begin
            // Blank or multi-anode patterns park in IDLE until the bus moves.
            state_d = single_sel ? ST_SETTLE : ST_IDLE;
        end else begin
            case (state_q)
                ST_SETTLE: if (settle_cnt_q == SETTLE_LAST) state_d = ST_HOLD;
                default:   state_d = state_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        capture     = 1'b0;
        multi_first = 1'b0;
        if (state_q == ST_SETTLE && !changed && settle_cnt_q == SETTLE_LAST)
            capture = 1'b1;
        // Only the entry into a multi-anode condition is reported.
        if (changed && multi_sel && !multi_prev)
            multi_first = 1'b1;
    end

    // ------------------------------------------------------------------
    // Previous-sample registers and settle counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // Reset to the blank-display pattern.
            an_q         <= 4'hF;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            settle_cnt_q <= 8'd0;
        end else begin
            an_q  <= bus.an_i;
            seg_q <= bus.seg_i;
            dp_q  <= bus.dp_i;
            if (changed)
                settle_cnt_q <= 8'd0;
            else if (state_q == ST_SETTLE)
                settle_cnt_q <= settle_cnt_q + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Optional idle timeout
    // ------------------------------------------------------------------
`ifdef SCAN_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);
    logic [31:0] idle_cnt_q;

    assign timeout_hit = !capture && !complete && (idle_cnt_q == TIMEOUT_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                      idle_cnt_q <= 32'd0;
        else if (capture || complete)     idle_cnt_q <= 32'd0;
        else if (timeout_hit)             idle_cnt_q <= 32'd0;
        else                              idle_cnt_q <= idle_cnt_q + 32'd1;
    end
`else
    // TIMEOUT_CYC only matters when the idle counter is built.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign timeout_hit        = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Capture, frame assembly and publication
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seen_q        <= 4'd0;
            flag_q        <= 1'b0;
            shadow_q      <= 16'd0;
            shadow_dp_q   <= 4'd0;
            value_q       <= 16'd0;
            dp_out_q      <= 4'd0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            multi_q       <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            multi_q       <= multi_first;
            timeout_q     <= timeout_hit;

            // A capture can never land on the edge after a capture (the dwell
            // is at least two cycles), so complete and capture are exclusive.
            if (complete) begin
                value_q       <= shadow_q;
                dp_out_q      <= shadow_dp_q;
                frame_valid_q <= 1'b1;
                frame_err_q   <= flag_q;
                seen_q        <= 4'd0;
                flag_q        <= 1'b0;
            end else if (capture) begin
                shadow_q[{sel_idx, 2'b00} +: 4] <= dec[3:0];
                shadow_dp_q[sel_idx]            <= ~bus.dp_i;
                seen_q[sel_idx]                 <= 1'b1;
                if (!dec[4]) flag_q <= 1'b1;
            end

            if (multi_first || timeout_hit) begin
                seen_q <= 4'd0;
                flag_q <= 1'b0;
            end
        end
    end

    assign bus.value_o        = value_q;
    assign bus.dp_o           = dp_out_q;
    assign bus.frame_valid_o  = frame_valid_q;
    assign bus.frame_err_o    = frame_err_q;
    assign bus.multi_an_err_o = multi_q;
    assign bus.timeout_o      = timeout_q;
    assign bus.state_o        = state_q;

endmodule

// File: doc/seven_seg_scan_decoder.md
SEVEN_SEG_SCAN_DECODER -- requirements
Module: seven_seg_scan_decoder

Interface
REQ-001 Parameter SETTLE_CYC, default 4, number of consecutive stable cycles required before a digit is captured (legal range 2..255).
REQ-002 Parameter TIMEOUT_CYC, default 1_000_000, idle cycles without a capture before the frame is aborted (used only with SCAN_TIMEOUT_EN).
REQ-003 clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 an_i  input  4  anode enables, active-low; an_i[0] is the rightmost digit, an_i[3] the leftmost.
REQ-006 seg_i  input  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-007 dp_i  input  1  decimal point, active-low.
REQ-008 value_o  output  16  last complete frame as 4 BCD nibbles; nibble k is digit k.
REQ-009 dp_o  output  4  last complete frame decimal points, active-high; bit k is digit k.
REQ-010 frame_valid_o  output  1  one-cycle pulse when value_o/dp_o update.
REQ-011 frame_err_o  output  1  valid with frame_valid_o; 1 if any digit in that frame failed decode.
REQ-012 multi_an_err_o  output  1  one-cycle pulse when more than one an_i bit is low.
REQ-013 timeout_o  output  1  one-cycle pulse on scan timeout.

Function
REQ-014 Inputs are in the clk_i domain; no synchronizers are instantiated.
REQ-015 FSM states: IDLE (an_i = 4'hF or no valid selection), SETTLE (single anode low, counting stability), HOLD (digit captured, waiting for change).
REQ-016 Any change of {an_i, seg_i, dp_i} versus the previous cycle reloads the settle counter to 0 and moves to SETTLE (single anode low) or IDLE (all anodes high).
REQ-017 In SETTLE, when the counter reaches SETTLE_CYC-1 with inputs unchanged, the digit is captured on that edge and the FSM enters HOLD; exactly one capture per dwell.
REQ-018 Decode, active-low patterns: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10; any other pattern stores 4'hF and sets the frame error flag.
REQ-019 Capture writes the nibble and dp (inverted dp_i) into a shadow register at the selected index and sets seen[index]; a repeated index overwrites.
REQ-020 When seen becomes 4'b1111, on the next edge value_o/dp_o load from the shadow (including the digit just captured), frame_valid_o pulses, frame_err_o reflects the flag, seen and flag clear.
REQ-021 More than one an_i bit low: multi_an_err_o pulses on the first such cycle only, seen and flag clear, FSM goes to IDLE and remains there until an_i changes.
REQ-022 value_o and dp_o hold between frames; aborted frames never modify them.
REQ-023 frame_err_o is 0 whenever frame_valid_o is 0.

Reset
REQ-024 rst_ni low asynchronously forces FSM to IDLE, counters 0, seen 4'b0000, shadow 0, value_o 16'h0000, dp_o 4'h0, and all pulse outputs 0.
REQ-025 Reset mid-frame discards partial captures; the first frame after release requires all four digits anew.

Configuration
REQ-026 Macro SCAN_TIMEOUT_EN defined: an idle counter clears on every capture and on frame completion, otherwise increments; when it reaches TIMEOUT_CYC, timeout_o pulses for one cycle, seen and flag clear, counter restarts at 0.
REQ-027 Macro SCAN_TIMEOUT_EN undefined: no idle counter is built, timeout_o is constant 0, frames may span unlimited time.

Verification
REQ-028 Scan "1234" (an_i 4'b0111 seg 7'h79, 4'b1011 7'h24, 4'b1101 7'h30, 4'b1110 7'h19), 8 cycles each -> one frame_valid_o, value_o=16'h1234, frame_err_o=0.
REQ-029 Same scan with dp_i=0 on digit 2 -> dp_o=4'b0100.
REQ-030 Digit 1 holds pattern 7'h7F -> value_o nibble 1 = 4'hF, frame_err_o=1 with frame_valid_o.
REQ-031 Glitch: digit held only SETTLE_CYC-1 cycles -> no capture, no frame_valid_o until a full dwell.
REQ-032 an_i=4'b1100 for 5 cycles mid-frame -> one multi_an_err_o pulse, value_o unchanged, next frame needs four fresh digits.
REQ-033 SCAN_TIMEOUT_EN, TIMEOUT_CYC=100: three digits then an_i=4'hF for 100 cycles -> timeout_o pulse, no frame_valid_o; rst_ni low mid-frame -> all outputs 0 immediately.
